delayed_update_checker: RTL and testbench
=========================================

# delayed_update_checker

Synthesizable self-check monitor that reads a register driven by a delayed-update writer and decides pass/fail. It confirms that the observed register holds its initial value throughout a settle window. It then confirms the register takes the expected value before a timeout. It sits beside the writer under test in the ivltests regression bench and reports a sticky verdict that the bench prints as PASSED/FAILED.

## Interface
Parameters:
- WIDTH, 4, width of the observed value.
- INIT_VAL, 4'h0, value required during the settle window.
- EXPECT_VAL, 4'h1, value that must appear after the settle window.
- SETTLE_CYCLES, 10, number of sampled edges that must show INIT_VAL. Legal range 1..254.
- TIMEOUT_CYCLES, 15, last sampled edge allowed to show EXPECT_VAL. Must satisfy SETTLE_CYCLES < TIMEOUT_CYCLES ≤ 255.

Ports (name, direction, width, meaning):
- clk, in, 1, single clock. All state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begins a check when sampled high in IDLE, PASS or FAIL.
- value, in, WIDTH, register under observation. It must be synchronous to clk.
- busy, out, 1, high in SETTLE or WAIT.
- done, out, 1, high in PASS or FAIL.
- pass, out, 1, high in PASS.
- fail, out, 1, high in FAIL.
- err_code, out, 2, failure cause: 0 none, 1 early update, 2 timeout, 3 wrong value.
- cycle_count, out, 8, index of the last sampled edge since start.

## Operation
- States: IDLE, SETTLE, WAIT, PASS, FAIL.
- Reset (async, rst_n low) forces IDLE. Outputs on reset: busy=0, done=0, pass=0, fail=0, err_code=0, cycle_count=0.
- Start: start is ignored while busy. When start is sampled in IDLE, PASS or FAIL:
  - the FSM goes to SETTLE;
  - cycle_count becomes 0 and err_code becomes 0;
  - pass and fail clear.
- Edge numbering: the start edge is edge 0. Each later edge n samples value and sets cycle_count=n.
- SETTLE (edges 1..SETTLE_CYCLES):
  - value ≠ INIT_VAL: go to FAIL with err_code=1.
  - value = INIT_VAL at edge SETTLE_CYCLES: go to WAIT.
- WAIT (edges SETTLE_CYCLES+1..TIMEOUT_CYCLES):
  - value = EXPECT_VAL: go to PASS.
  - value = INIT_VAL and n < TIMEOUT_CYCLES: stay in WAIT.
  - value = INIT_VAL and n = TIMEOUT_CYCLES: go to FAIL with err_code=2.
  - any other value: go to FAIL with err_code=3.
- Value comparisons use the full WIDTH with exact equality.
- PASS and FAIL are sticky. cycle_count and err_code freeze until the next start or reset.
- Verdict priority at a single edge: EXPECT_VAL match is checked first, then INIT_VAL, then the wrong-value case.

## Timing
- All outputs are registered and decoded from state, so there are no combinational paths from inputs.
- Verdict latency is one edge. A value that changes before edge n is judged at edge n, and pass/fail is visible right after edge n.
- busy rises on the cycle after the start edge. done rises on the cycle after the deciding edge.
- Start sampled in PASS or FAIL restarts on the same edge. done drops and busy rises in the next cycle.
- Reset asserted mid-check takes effect immediately, without waiting for clk. The block returns to IDLE and all outputs are 0. No verdict is produced until a new start.
- cycle_count never wraps because TIMEOUT_CYCLES ≤ 255.

## Test plan
- Nominal writer: value=0, start at edge 0, value becomes 1 before edge 11. Required: pass=1, err_code=0, cycle_count=11, done=1 from edge 11 onward.
- Early update: value becomes 1 before edge 4. Required: fail=1, err_code=1, cycle_count=4.
- Writer never fires: value stays 0. Required: fail=1, err_code=2, cycle_count=15. pass is never high.
- Wrong value: value becomes 4'h7 before edge 12. Required: fail=1, err_code=3, cycle_count=12.
- Reset mid-check: rst_n low during edge 6 with no clock edge needed. Required: all outputs 0 immediately. A later start plus the nominal writer gives pass with cycle_count=11.
- Restart and ignore: start is held high during SETTLE and has no effect. After FAIL, start again with a nominal writer. Required: fail clears, then pass=1 with cycle_count=11.

Source files
------------

// File: rtl/delayed_update_checker_if.sv
// Bundle of the checker's control/observation signals.
// The bench drives through master; the checker attaches to slave.
interface delayed_update_checker_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [1:0]       err_code;
  logic [7:0]       cycle_count;

  modport master (
    output start, value,
    input  busy, done, pass, fail, err_code, cycle_count
  );

  modport slave (
    input  start, value,
    output busy, done, pass, fail, err_code, cycle_count
  );
endinterface

// File: rtl/delayed_update_checker.sv
// Monitor that requires INIT_VAL for a settle window, then EXPECT_VAL
// before a timeout, and holds a sticky pass/fail verdict.
module delayed_update_checker #(
  parameter int                 WIDTH          = 4,
  parameter logic [WIDTH-1:0]   INIT_VAL       = 4'h0,
  parameter logic [WIDTH-1:0]   EXPECT_VAL     = 4'h1,
  parameter int                 SETTLE_CYCLES  = 10,
  parameter int                 TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  delayed_update_checker_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    WAIT   = 3'd2,
    PASS   = 3'd3,
    FAIL   = 3'd4
  } state_t;

  localparam logic [7:0] SETTLE_N  = 8'(SETTLE_CYCLES);
  localparam logic [7:0] TIMEOUT_N = 8'(TIMEOUT_CYCLES);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_EARLY   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_WRONG   = 2'd3;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [1:0] err_reg, err_next;
  logic [7:0] edge_n;
  logic       is_init;
  logic       is_expect;

  // Index of the edge currently being judged while a check is running.
  assign edge_n    = cnt_reg + 8'd1;
  assign is_init   = (bus.value == INIT_VAL);
  assign is_expect = (bus.value == EXPECT_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      err_reg   <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE, PASS, FAIL: begin
        if (bus.start) begin
          state_next = SETTLE;
          cnt_next   = 8'd0;
          err_next   = ERR_NONE;
        end
      end
      SETTLE: begin
        cnt_next = edge_n;
        if (!is_init) begin
          state_next = FAIL;
          err_next   = ERR_EARLY;
        end else if (edge_n == SETTLE_N) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = edge_n;
        // A match on EXPECT_VAL wins even if it also equals INIT_VAL.
        if (is_expect) begin
          state_next = PASS;
        end else if (is_init) begin
          if (edge_n == TIMEOUT_N) begin
            state_next = FAIL;
            err_next   = ERR_TIMEOUT;
          end
        end else begin
          state_next = FAIL;
          err_next   = ERR_WRONG;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
        err_next   = ERR_NONE;
      end
    endcase
  end

  always_comb begin
    bus.busy        = (state_reg == SETTLE) || (state_reg == WAIT);
    bus.done        = (state_reg == PASS) || (state_reg == FAIL);
    bus.pass        = (state_reg == PASS);
    bus.fail        = (state_reg == FAIL);
    bus.err_code    = err_reg;
    bus.cycle_count = cnt_reg;
  end

endmodule

// File: tb/tb_delayed_update_checker.sv
// Bench for delayed_update_checker: directed vector table, random writers
// checked against a closed-form verdict model, reset and restart sequences.
module tb_delayed_update_checker;

  localparam int         W    = 4;
  localparam logic [3:0] INIT = 4'h0;
  localparam logic [3:0] EXPV = 4'h1;
  localparam int         S    = 10;
  localparam int         T    = 15;

  logic clk;
  logic rst_n;

  delayed_update_checker_if #(.WIDTH(W)) bus ();

  delayed_update_checker #(
    .WIDTH(W), .INIT_VAL(INIT), .EXPECT_VAL(EXPV),
    .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  typedef struct {
    int         chg;
    logic [3:0] val;
    int         exp_d;
    int         exp_err;
  } vec_t;

  // Packed observation: {busy, done, pass, fail, err_code, cycle_count}
  function automatic logic [13:0] observe();
    return {bus.busy, bus.done, bus.pass, bus.fail, bus.err_code, bus.cycle_count};
  endfunction

  function automatic logic [13:0] pack(input logic b, input logic d, input logic p,
                                       input logic f, input int e, input int c);
    return {b, d, p, f, 2'(e), 8'(c)};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h (b/d/p/f=%b err=%0d cc=%0d) want %h (b/d/p/f=%b err=%0d cc=%0d)",
               name, act, act[13:10], act[9:8], act[7:0], req, req[13:10], req[9:8], req[7:0]);
    end
  endtask

  // Writer switches to val from edge chg onward. The verdict follows from
  // where that switch lands relative to the settle and timeout windows.
  task automatic model(input int chg, input logic [3:0] val, output int d, output int err);
    if (val == INIT || chg > T) begin
      d = T; err = 2;
    end else if (chg <= S) begin
      d = chg; err = 1;
    end else if (val == EXPV) begin
      d = chg; err = 0;
    end else begin
      d = chg; err = 3;
    end
  endtask

  task automatic run_check(input string name, input int chg, input logic [3:0] val,
                           input int exp_d, input int exp_err, input bit hold);
    logic [13:0] req;
    @(negedge clk);
    bus.value = INIT;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check({name, "/start"}, observe(), pack(1, 0, 0, 0, 0, 0));
    for (int n = 1; n <= exp_d + 2; n++) begin
      @(negedge clk);
      bus.start = hold && (n < S);
      bus.value = (n >= chg) ? val : INIT;
      @(posedge clk);
      #1;
      if (n < exp_d) req = pack(1, 0, 0, 0, 0, n);
      else           req = pack(0, 1, exp_err == 0, exp_err != 0, exp_err, exp_d);
      check($sformatf("%s/e%0d", name, n), observe(), req);
    end
    $display("check %-10s chg=%0d val=%h -> pass=%b fail=%b err=%0d cc=%0d",
             name, chg, val, bus.pass, bus.fail, bus.err_code, bus.cycle_count);
  endtask

  vec_t table_v[$];

  initial begin
    int d, e, chg;
    logic [3:0] val;
    vectors     = 0;
    miscompares = 0;

    table_v.push_back('{11, 4'h1, 11, 0});   // nominal writer
    table_v.push_back('{4,  4'h1, 4,  1});   // early update
    table_v.push_back('{99, 4'h1, 15, 2});   // writer never fires
    table_v.push_back('{12, 4'h7, 12, 3});   // wrong value
    table_v.push_back('{1,  4'h1, 1,  1});   // first settle edge
    table_v.push_back('{10, 4'h1, 10, 1});   // last settle edge
    table_v.push_back('{15, 4'h1, 15, 0});   // last allowed edge
    table_v.push_back('{16, 4'h1, 15, 2});   // one edge too late
    table_v.push_back('{5,  4'hF, 5,  1});   // non-expect value in settle
    table_v.push_back('{15, 4'h8, 15, 3});   // wrong value on timeout edge

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.value = INIT;
    #12;
    check("reset", observe(), pack(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold", observe(), pack(0, 0, 0, 0, 0, 0));

    foreach (table_v[i])
      run_check($sformatf("tbl%0d", i), table_v[i].chg, table_v[i].val,
                table_v[i].exp_d, table_v[i].exp_err, 1'b0);

    for (int r = 0; r < 25; r++) begin
      chg = int'($urandom_range(1, 18));
      val = 4'($urandom_range(0, 15));
      model(chg, val, d, e);
      run_check($sformatf("rnd%0d", r), chg, val, d, e, 1'b0);
    end

    // Reset mid-check, between clock edges.
    @(negedge clk);
    bus.value = INIT;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid", observe(), pack(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("rst_held", observe(), pack(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_verdict", observe(), pack(0, 0, 0, 0, 0, 0));
    $display("check rst_mid    -> outputs cleared, idle until start");
    run_check("post_rst", 11, 4'h1, 11, 0, 1'b0);

    // start held during settle is ignored; a restart from FAIL clears it.
    run_check("hold_fail", 99, 4'h1, 15, 2, 1'b1);
    run_check("restart", 11, 4'h1, 11, 0, 1'b1);
    run_check("from_pass", 13, 4'h2, 13, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
